sram_arbiter: RTL and testbench

Parametrised shared-SRAM controller with N requester channels, programmable wait states and selectable arbitration. It sits between the pipeline's fetch and memory stages (and optional extra masters) and the single external asynchronous SRAM. It replaces the single-master, single-cycle RAM wrapper so that instruction fetch and data access can share one chip, with an explicit stall/ack handshake per channel.

---
 rtl/sram_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_sram_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Shared asynchronous-SRAM controller: NCH requesters, programmable wait states,
// round-robin or fixed-priority arbitration. Every output is driven from a flop.
module sram_arbiter #(
   parameter int ADDR_W      = 18,
   parameter int DATA_W      = 16,
   parameter int NCH         = 2,
   parameter int WAIT_CYCLES = 1,
   parameter int FIXED_PRIO  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCH-1:0]        req,
   input  logic [NCH-1:0]        we,
   input  logic [NCH*ADDR_W-1:0] addr,
   input  logic [NCH*DATA_W-1:0] wdata,
   output logic [NCH-1:0]        ack,
   output logic [DATA_W-1:0]     rdata,
   output logic                  busy,
   output logic [ADDR_W-1:0]     sram_addr,
   inout  wire  [DATA_W-1:0]     sram_data,
   output logic                  sram_en_n,
   output logic                  sram_oe_n,
   output logic                  sram_we_n
);
   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_HOLD   = 2'd3;
   localparam logic [2:0] CNT_LAST = 3'(WAIT_CYCLES);
   localparam logic [IW-1:0] LAST_RST = IW'(NCH - 1);

   logic [1:0]        state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [IW-1:0]     grant_q, grant_d;
   logic [IW-1:0]     last_q, last_d;
   logic              we_lat_q, we_lat_d;
   logic [ADDR_W-1:0] addr_lat_q, addr_lat_d;
   logic [DATA_W-1:0] wdata_lat_q, wdata_lat_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [NCH-1:0]    ack_q, ack_d;
   logic              busy_q, busy_d;
   logic              en_n_q, en_n_d;
   logic              oe_n_q, oe_n_d;
   logic              we_n_q, we_n_d;
   logic              drive_q, drive_d;
   logic [IW-1:0]     winner;
   logic [IW-1:0]     cand;
   logic              req_any;

   // Winner selection; round-robin scans downward so the channel nearest after last_q wins.
   always_comb begin
      winner  = last_q;
      cand    = last_q;
      req_any = |req;
      if (FIXED_PRIO != 0) begin
         for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) begin
               winner = IW'(i);
            end else begin
               winner = winner;
            end
         end
      end else begin
         for (int k = NCH; k >= 1; k--) begin
            cand = IW'((int'(last_q) + k) % NCH);
            if (req[cand]) begin
               winner = cand;
            end else begin
               winner = winner;
            end
         end
      end
   end

   // Transaction FSM and registered SRAM strobes derived from the next state.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      grant_d     = grant_q;
      last_d      = last_q;
      we_lat_d    = we_lat_q;
      addr_lat_d  = addr_lat_q;
      wdata_lat_d = wdata_lat_q;
      rdata_d     = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (req_any) begin
               state_d = S_SETUP;
               grant_d = winner;
               last_d  = winner;
               for (int i = 0; i < NCH; i++) begin
                  if (IW'(i) == winner) begin
                     we_lat_d    = we[i];
                     addr_lat_d  = addr[i*ADDR_W +: ADDR_W];
                     wdata_lat_d = wdata[i*DATA_W +: DATA_W];
                  end else begin
                     we_lat_d = we_lat_d;
                  end
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SETUP: begin
            state_d = S_ACCESS;
            cnt_d   = 3'd0;
         end
         S_ACCESS: begin
            if (cnt_q == CNT_LAST) begin
               state_d = S_HOLD;
               cnt_d   = 3'd0;
               if (!we_lat_q) begin
                  rdata_d = sram_data;
               end else begin
                  rdata_d = rdata_q;
               end
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_HOLD: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d  = (state_d != S_IDLE);
      en_n_d  = (state_d == S_IDLE);
      oe_n_d  = !(!we_lat_d && ((state_d == S_SETUP) || (state_d == S_ACCESS)));
      we_n_d  = !(we_lat_d && (state_d == S_ACCESS));
      drive_d = we_lat_d && (state_d != S_IDLE);
      for (int i = 0; i < NCH; i++) begin
         ack_d[i] = (state_d == S_HOLD) && (grant_q == IW'(i));
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 3'd0;
         grant_q     <= '0;
         last_q      <= LAST_RST;
         we_lat_q    <= 1'b0;
         addr_lat_q  <= '0;
         wdata_lat_q <= '0;
         rdata_q     <= '0;
         ack_q       <= '0;
         busy_q      <= 1'b0;
         en_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         drive_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         we_lat_q    <= we_lat_d;
         addr_lat_q  <= addr_lat_d;
         wdata_lat_q <= wdata_lat_d;
         rdata_q     <= rdata_d;
         ack_q       <= ack_d;
         busy_q      <= busy_d;
         en_n_q      <= en_n_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
         drive_q     <= drive_d;
      end
   end

   assign ack       = ack_q;
   assign rdata     = rdata_q;
   assign busy      = busy_q;
   assign sram_addr = addr_lat_q;
   assign sram_en_n = en_n_q;
   assign sram_oe_n = oe_n_q;
   assign sram_we_n = we_n_q;
   assign sram_data = drive_q ? wdata_lat_q : {DATA_W{1'bz}};
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: five instances cover round-robin, fixed priority,
// zero and seven wait states, and a four-channel round-robin configuration.
module tb_sram_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   clash = 0;
   int   a_oel = 0, a_ackn = 0, z_wel = 0, z_oel = 0, s_wel = 0, s_oel = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // A: NCH=2, WAIT_CYCLES=1, round-robin, backed by a small memory model
   logic [1:0]  a_req = 2'b00, a_we = 2'b00, a_ack;
   logic [35:0] a_addr = 36'd0;
   logic [31:0] a_wdata = 32'd0;
   logic [15:0] a_rdata;
   logic [17:0] a_saddr;
   logic        a_busy, a_en_n, a_oe_n, a_we_n;
   wire  [15:0] a_data;
   logic [15:0] mem [0:255];
   assign a_data = (!a_en_n && !a_oe_n) ? mem[a_saddr[7:0]] : 16'hzzzz;
   always @(posedge clk) if (!a_en_n && !a_we_n) mem[a_saddr[7:0]] <= a_data;

   sram_arbiter #(.ADDR_W(18), .DATA_W(16), .NCH(2), .WAIT_CYCLES(1), .FIXED_PRIO(0)) u_a (
      .clk(clk), .rst(rst), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata),
      .ack(a_ack), .rdata(a_rdata), .busy(a_busy), .sram_addr(a_saddr), .sram_data(a_data),
      .sram_en_n(a_en_n), .sram_oe_n(a_oe_n), .sram_we_n(a_we_n));

   // F: fixed priority
   logic [1:0]  f_req = 2'b00, f_we = 2'b00, f_ack;
   logic [35:0] f_addr = 36'd0;
   logic [31:0] f_wdata = 32'd0;
   logic [15:0] f_rdata;
   logic [17:0] f_saddr;
   logic        f_busy, f_en_n, f_oe_n, f_we_n;
   wire  [15:0] f_data;
   assign f_data = (!f_en_n && !f_oe_n) ? 16'h0F0F : 16'hzzzz;

   sram_arbiter #(.ADDR_W(18), .DATA_W(16), .NCH(2), .WAIT_CYCLES(1), .FIXED_PRIO(1)) u_f (
      .clk(clk), .rst(rst), .req(f_req), .we(f_we), .addr(f_addr), .wdata(f_wdata),
      .ack(f_ack), .rdata(f_rdata), .busy(f_busy), .sram_addr(f_saddr), .sram_data(f_data),
      .sram_en_n(f_en_n), .sram_oe_n(f_oe_n), .sram_we_n(f_we_n));

   // Z: zero wait states
   logic [1:0]  z_req = 2'b00, z_we = 2'b00, z_ack;
   logic [35:0] z_addr = 36'd0;
   logic [31:0] z_wdata = 32'd0;
   logic [15:0] z_rdata;
   logic [17:0] z_saddr;
   logic        z_busy, z_en_n, z_oe_n, z_we_n;
   wire  [15:0] z_data;
   assign z_data = (!z_en_n && !z_oe_n) ? 16'hA5A5 : 16'hzzzz;

   sram_arbiter #(.ADDR_W(18), .DATA_W(16), .NCH(2), .WAIT_CYCLES(0), .FIXED_PRIO(0)) u_z (
      .clk(clk), .rst(rst), .req(z_req), .we(z_we), .addr(z_addr), .wdata(z_wdata),
      .ack(z_ack), .rdata(z_rdata), .busy(z_busy), .sram_addr(z_saddr), .sram_data(z_data),
      .sram_en_n(z_en_n), .sram_oe_n(z_oe_n), .sram_we_n(z_we_n));

   // S: seven wait states
   logic [1:0]  s_req = 2'b00, s_we = 2'b00, s_ack;
   logic [35:0] s_addr = 36'd0;
   logic [31:0] s_wdata = 32'd0;
   logic [15:0] s_rdata;
   logic [17:0] s_saddr;
   logic        s_busy, s_en_n, s_oe_n, s_we_n;
   wire  [15:0] s_data;
   assign s_data = (!s_en_n && !s_oe_n) ? 16'h5A5A : 16'hzzzz;

   sram_arbiter #(.ADDR_W(18), .DATA_W(16), .NCH(2), .WAIT_CYCLES(7), .FIXED_PRIO(0)) u_s (
      .clk(clk), .rst(rst), .req(s_req), .we(s_we), .addr(s_addr), .wdata(s_wdata),
      .ack(s_ack), .rdata(s_rdata), .busy(s_busy), .sram_addr(s_saddr), .sram_data(s_data),
      .sram_en_n(s_en_n), .sram_oe_n(s_oe_n), .sram_we_n(s_we_n));

   // N: four channels; read data is the low address bits xor 0x5A5A
   logic [3:0]  n_req = 4'b0000, n_we = 4'b0000, n_ack;
   logic [71:0] n_addr = 72'd0;
   logic [63:0] n_wdata = 64'd0;
   logic [15:0] n_rdata;
   logic [17:0] n_saddr;
   logic        n_busy, n_en_n, n_oe_n, n_we_n;
   wire  [15:0] n_data;
   assign n_data = (!n_en_n && !n_oe_n) ? (n_saddr[15:0] ^ 16'h5A5A) : 16'hzzzz;

   sram_arbiter #(.ADDR_W(18), .DATA_W(16), .NCH(4), .WAIT_CYCLES(1), .FIXED_PRIO(0)) u_n (
      .clk(clk), .rst(rst), .req(n_req), .we(n_we), .addr(n_addr), .wdata(n_wdata),
      .ack(n_ack), .rdata(n_rdata), .busy(n_busy), .sram_addr(n_saddr), .sram_data(n_data),
      .sram_en_n(n_en_n), .sram_oe_n(n_oe_n), .sram_we_n(n_we_n));

   // Strobe-width, ack and oe/we overlap bookkeeping, sampled mid-cycle
   always @(negedge clk) begin
      if ((!a_oe_n && !a_we_n) || (!f_oe_n && !f_we_n) || (!z_oe_n && !z_we_n) ||
          (!s_oe_n && !s_we_n) || (!n_oe_n && !n_we_n)) clash <= clash + 1;
      if (!a_oe_n) a_oel <= a_oel + 1;
      if (a_ack != 2'b00) a_ackn <= a_ackn + 1;
      if (!z_we_n) z_wel <= z_wel + 1;
      if (!z_oe_n) z_oel <= z_oel + 1;
      if (!s_we_n) s_wel <= s_wel + 1;
      if (!s_oe_n) s_oel <= s_oel + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance until the chosen instance shows an ack, bounded to 40 cycles.
   task automatic wait_ack(input int inst, input string tag, output int c, output logic [7:0] id);
      logic got = 1'b0;
      id = 8'h00;
      c  = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         case (inst)
            0:       id = 8'(a_ack);
            1:       id = 8'(f_ack);
            2:       id = 8'(z_ack);
            3:       id = 8'(s_ack);
            default: id = 8'(n_ack);
         endcase
         if (id != 8'h00) begin
            got = 1'b1;
            c   = cyc;
            break;
         end
      end
      check({tag, "_seen"}, 32'(got), 32'h1);
   endtask

   initial begin
      int c0, c, prev, snap;
      logic [7:0] id;

      repeat (3) step();
      check("rst_en_n",  32'(a_en_n),  32'h1);
      check("rst_oe_n",  32'(a_oe_n),  32'h1);
      check("rst_we_n",  32'(a_we_n),  32'h1);
      check("rst_ack",   32'(a_ack),   32'h0);
      check("rst_busy",  32'(a_busy),  32'h0);
      check("rst_rdata", 32'(a_rdata), 32'h0);
      check("rst_saddr", 32'(a_saddr), 32'h0);
      check("rst_bus_z", 32'(a_data === 16'hzzzz), 32'h1);
      rst = 1'b0;
      step();

      // write 0xBEEF to 0x00123 on ch0, cycle by cycle
      a_req = 2'b01; a_we = 2'b01; a_addr[17:0] = 18'h00123; a_wdata[15:0] = 16'hBEEF;
      check("wr_busy_c0", 32'(a_busy), 32'h0);
      step();
      check("wr_busy_c1", 32'(a_busy), 32'h1);
      check("wr_we_n_c1", 32'(a_we_n), 32'h1);
      check("wr_bus_c1",  32'(a_data), 32'hBEEF);
      step();
      check("wr_we_n_c2", 32'(a_we_n), 32'h0);
      step();
      check("wr_we_n_c3", 32'(a_we_n), 32'h0);
      step();
      check("wr_we_n_c4", 32'(a_we_n), 32'h1);
      check("wr_ack_c4",  32'(a_ack),  32'h1);
      step();
      a_req = 2'b00;
      check("wr_busy_c5", 32'(a_busy), 32'h0);
      check("wr_ack_c5",  32'(a_ack),  32'h0);
      step();

      // read it back
      a_we = 2'b00; snap = a_oel; c0 = cyc; a_req = 2'b01;
      wait_ack(0, "rd", c, id);
      check("rd_ack_cyc", c - c0, 32'd4);
      check("rd_ack_id",  32'(id), 32'h1);
      check("rd_rdata",   32'(a_rdata), 32'hBEEF);
      step();
      a_req = 2'b00;
      check("rd_oe_width", a_oel - snap, 32'd3);
      step();

      // simultaneous requests after reset alternate 0,1,0,1 every 5 cycles
      rst = 1'b1; step(); rst = 1'b0;
      a_addr[35:18] = 18'h00123; a_we = 2'b00; a_req = 2'b11; c0 = cyc; prev = c0 - 1;
      for (int k = 0; k < 4; k++) begin
         wait_ack(0, "rr", c, id);
         check("rr_id", 32'(id), (k % 2 == 0) ? 32'h1 : 32'h2);
         check("rr_spacing", c - prev, (k == 0) ? 32'd5 : 32'd5);
         prev = c;
      end
      step();
      a_req = 2'b00;
      step();

      // reset asserted for two cycles in the middle of a write
      a_req = 2'b01; a_we = 2'b01; a_addr[17:0] = 18'h00055; a_wdata[15:0] = 16'h1234;
      step(); step();
      check("ab_we_n_c2", 32'(a_we_n), 32'h0);
      snap = a_ackn;
      rst = 1'b1; a_req = 2'b00;
      step();
      check("ab_en_n",  32'(a_en_n),  32'h1);
      check("ab_we_n",  32'(a_we_n),  32'h1);
      check("ab_oe_n",  32'(a_oe_n),  32'h1);
      check("ab_bus_z", 32'(a_data === 16'hzzzz), 32'h1);
      check("ab_ack",   32'(a_ack),   32'h0);
      check("ab_busy",  32'(a_busy),  32'h0);
      check("ab_rdata", 32'(a_rdata), 32'h0);
      check("ab_saddr", 32'(a_saddr), 32'h0);
      step();
      rst = 1'b0;
      repeat (10) step();
      check("ab_no_ack", a_ackn - snap, 32'd0);

      // fixed priority: ch0 always wins, ch1 served only once ch0 drops
      f_req = 2'b11; f_we = 2'b00; c0 = cyc; prev = c0 - 1;
      for (int k = 0; k < 4; k++) begin
         wait_ack(1, "fp", c, id);
         check("fp_id", 32'(id), 32'h1);
         check("fp_spacing", c - prev, 32'd5);
         prev = c;
      end
      f_req = 2'b10;
      wait_ack(1, "fp_ch1", c, id);
      check("fp_ch1_id", 32'(id), 32'h2);
      check("fp_rdata",  32'(f_rdata), 32'h0F0F);
      step();
      f_req = 2'b00;

      // zero wait states
      z_we = 2'b01; z_wdata[15:0] = 16'h0001; snap = z_wel; c0 = cyc; z_req = 2'b01;
      wait_ack(2, "w0_wr", c, id);
      check("w0_wr_cyc", c - c0, 32'd3);
      step();
      z_req = 2'b00;
      check("w0_we_width", z_wel - snap, 32'd1);
      step();
      z_we = 2'b00; snap = z_oel; c0 = cyc; z_req = 2'b01;
      wait_ack(2, "w0_rd", c, id);
      check("w0_rd_cyc", c - c0, 32'd3);
      check("w0_rdata",  32'(z_rdata), 32'hA5A5);
      step();
      z_req = 2'b00;
      check("w0_oe_width", z_oel - snap, 32'd2);

      // seven wait states
      s_we = 2'b01; s_wdata[15:0] = 16'h0007; snap = s_wel; c0 = cyc; s_req = 2'b01;
      wait_ack(3, "w7_wr", c, id);
      check("w7_wr_cyc", c - c0, 32'd10);
      step();
      s_req = 2'b00;
      check("w7_we_width", s_wel - snap, 32'd8);
      step();
      s_we = 2'b00; snap = s_oel; c0 = cyc; s_req = 2'b01;
      wait_ack(3, "w7_rd", c, id);
      check("w7_rd_cyc", c - c0, 32'd10);
      check("w7_rdata",  32'(s_rdata), 32'h5A5A);
      step();
      s_req = 2'b00;
      check("w7_oe_width", s_oel - snap, 32'd9);

      // four channels: ch1 read sets pointer=1, then 1010 grants ch3 (write) before ch1
      n_we = 4'b0000; n_addr[35:18] = 18'h00111; n_req = 4'b0010;
      wait_ack(4, "n4_first", c, id);
      check("n4_first_id", 32'(id), 32'h2);
      check("n4_first_rd", 32'(n_rdata), 32'h5B4B);
      n_addr[35:18] = 18'h00222; n_addr[71:54] = 18'h00333; n_wdata[63:48] = 16'hCAFE;
      n_we = 4'b1000; n_req = 4'b1010;
      wait_ack(4, "n4_ch3", c, id);
      check("n4_ch3_id",     32'(id), 32'h8);
      check("n4_rdata_hold", 32'(n_rdata), 32'h5B4B);
      n_req = 4'b0010;
      wait_ack(4, "n4_ch1", c, id);
      check("n4_ch1_id", 32'(id), 32'h2);
      check("n4_ch1_rd", 32'(n_rdata), 32'h5878);
      step();
      n_req = 4'b0000;
      step();

      check("oe_we_overlap", clash, 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
